// File: rtl/port_link_bridge.sv
// External-side responder for the CPU 4-bit port: byte transfers in 3-bit chunks over a
// toggle handshake, bridged to valid/ready byte streams toward the fabric.
module port_link_bridge #(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] port_from_cpu,
   output logic [3:0] port_to_cpu,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       busy,
   output logic       err
);

   typedef enum logic [3:0] {
      StIdle, StW0, StW1, StW2, StWHold, StRWait, StR1, StR2, StR3
   } state_e;

   state_e           r_state;
   logic [3:0]       r_pin;
   logic             r_ctog_prev;
   logic             r_btog;
   logic [2:0]       r_bdata;
   logic [2:0]       r_chunk0;
   logic [2:0]       r_chunk1;
   logic [1:0]       r_chunk2;
   logic [7:0]       r_rbyte;
   logic [7:0]       r_m_data;
   logic             r_m_valid;
   logic             r_s_ready;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;

   logic       w_event;
   logic [2:0] w_cdata;
   logic       w_m_free;
   logic       w_timed;
   logic       w_cnt_run;
   logic       w_abort;

   always_comb begin
      w_event   = r_pin[3] ^ r_ctog_prev;
      w_cdata   = r_pin[2:0];
      w_m_free  = !r_m_valid || m_ready;
      w_timed   = (r_cnt == CNT_W'(TIMEOUT - 1));
      w_cnt_run = (r_state inside {StW0, StW1, StW2, StR1, StR2, StR3});
      // Timeout while waiting on the CPU, or the CPU toggled without waiting for our ack.
      w_abort   = (w_cnt_run && !w_event && w_timed) ||
                  (((r_state == StWHold) || (r_state == StRWait)) && w_event);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_pin       <= 4'b0000;
         r_ctog_prev <= 1'b0;
         r_btog      <= 1'b0;
         r_bdata     <= 3'b000;
         r_chunk0    <= 3'b000;
         r_chunk1    <= 3'b000;
         r_chunk2    <= 2'b00;
         r_rbyte     <= 8'h00;
         r_m_data    <= 8'h00;
         r_m_valid   <= 1'b0;
         r_s_ready   <= 1'b0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_pin       <= port_from_cpu;
         r_ctog_prev <= r_pin[3];
         r_s_ready   <= 1'b0;
         r_err       <= 1'b0;
         if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
         end
         if (w_event || !w_cnt_run) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_abort) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
            r_bdata <= 3'b000;
            r_rbyte <= 8'h00;
         end else begin
            case (r_state)
               StIdle: begin
                  if (w_event) begin
                     if (!w_cdata[2]) begin
                        // Not a header: still ack so the toggles stay paired.
                        r_btog  <= ~r_btog;
                        r_bdata <= 3'b000;
                        r_err   <= 1'b1;
                     end else if (w_cdata[1]) begin
                        r_state <= StRWait;
                     end else begin
                        r_btog  <= ~r_btog;
                        r_state <= StW0;
                     end
                  end
               end
               StW0: begin
                  if (w_event) begin
                     r_chunk0 <= w_cdata;
                     r_btog   <= ~r_btog;
                     r_state  <= StW1;
                  end
               end
               StW1: begin
                  if (w_event) begin
                     r_chunk1 <= w_cdata;
                     r_btog   <= ~r_btog;
                     r_state  <= StW2;
                  end
               end
               StW2: begin
                  if (w_event) begin
                     if (w_m_free) begin
                        r_m_data  <= {r_chunk0, r_chunk1, w_cdata[1:0]};
                        r_m_valid <= 1'b1;
                        r_btog    <= ~r_btog;
                        r_state   <= StIdle;
                     end else begin
                        r_chunk2 <= w_cdata[1:0];
                        r_state  <= StWHold;
                     end
                  end
               end
               StWHold: begin
                  if (w_m_free) begin
                     r_m_data  <= {r_chunk0, r_chunk1, r_chunk2};
                     r_m_valid <= 1'b1;
                     r_btog    <= ~r_btog;
                     r_state   <= StIdle;
                  end
               end
               StRWait: begin
                  if (s_valid) begin
                     r_rbyte   <= s_data;
                     r_s_ready <= 1'b1;
                     r_bdata   <= s_data[7:5];
                     r_btog    <= ~r_btog;
                     r_state   <= StR1;
                  end
               end
               StR1: begin
                  if (w_event) begin
                     r_bdata <= r_rbyte[4:2];
                     r_btog  <= ~r_btog;
                     r_state <= StR2;
                  end
               end
               StR2: begin
                  if (w_event) begin
                     r_bdata <= {1'b0, r_rbyte[1:0]};
                     r_btog  <= ~r_btog;
                     r_state <= StR3;
                  end
               end
               StR3: begin
                  if (w_event) begin
                     r_bdata <= 3'b000;
                     r_btog  <= ~r_btog;
                     r_state <= StIdle;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign port_to_cpu = {r_btog, r_bdata};
   assign s_ready     = r_s_ready;
   assign m_data      = r_m_data;
   assign m_valid     = r_m_valid;
   assign err         = r_err;
   assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_port_link_bridge.sv
// Bench for port_link_bridge: a CPU-side toggle-handshake driver, a fabric-side byte
// scoreboard, a table of directed transfers, error/timeout sequences and random traffic.
module tb_port_link_bridge;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] port_from_cpu;
   logic [3:0] port_to_cpu;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       busy;
   logic       err;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   int sready_cnt = 0;
   bit c_tog = 1'b0;
   bit b_tog_seen = 1'b0;
   bit rand_mready = 1'b0;
   bit man_mready = 1'b0;
   logic [7:0] m_exp_q[$];

   typedef struct {
      bit         dir;
      logic [7:0] data;
      logic [2:0] c0;
      logic [2:0] c1;
      logic [2:0] c2;
   } vec_t;

   port_link_bridge #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .port_from_cpu (port_from_cpu),
      .port_to_cpu   (port_to_cpu),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .busy          (busy),
      .err           (err)
   );

   initial forever #5 clk = ~clk;

   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         m_ready = rand_mready ? 1'($urandom_range(0, 1)) : man_mready;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Fabric-side scoreboard: every accepted m byte must match the oldest written byte.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (m_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL m_unexpected: got %0h expected no byte", m_data);
         end else begin
            check("m_data_order", m_data, m_exp_q.pop_front());
         end
      end
      if (err) err_cnt++;
      if (s_ready) sready_cnt++;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cpu_send(input logic [2:0] d);
      c_tog = ~c_tog;
      port_from_cpu = {c_tog, d};
   endtask

   task automatic wait_ack(input int budget, output int lat);
      lat = 0;
      do begin
         step();
         lat++;
      end while (port_to_cpu[3] == b_tog_seen && lat < budget);
      if (port_to_cpu[3] != b_tog_seen) b_tog_seen = port_to_cpu[3];
      else lat = -1;
   endtask

   task automatic ack_event(input string nm, input logic [2:0] d, input int exp_lat,
                            output logic [2:0] bd);
      int lat;
      cpu_send(d);
      wait_ack(100, lat);
      if (exp_lat > 0) check({nm, "_lat"}, lat, exp_lat);
      else check({nm, "_ack"}, 32'(lat >= 2), 1);
      bd = port_to_cpu[2:0];
   endtask

   task automatic do_write(input string nm, input logic [7:0] d, input logic [2:0] c0,
                           input logic [2:0] c1, input logic [2:0] c2, input bit h0,
                           input int exp_lat, input int gapmax);
      logic [2:0] bd;
      logic [2:0] ch[4];
      ch = '{{2'b10, h0}, c0, c1, c2};
      m_exp_q.push_back(d);
      for (int i = 0; i < 4; i++) begin
         if (gapmax > 0) step($urandom_range(0, gapmax));
         ack_event({nm, "_wev"}, ch[i], exp_lat, bd);
      end
      check({nm, "_busy_done"}, busy, 0);
      if (exp_lat > 0) begin
         check({nm, "_m_valid"}, m_valid, 1);
         check({nm, "_m_data"}, m_data, d);
      end
   endtask

   task automatic do_read(input string nm, input logic [7:0] d, input int delay, input bit exact,
                          input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2);
      int lat;
      int sr0;
      logic [2:0] bd[4];
      sr0 = sready_cnt;
      s_data = d;
      s_valid = (delay == 0);
      cpu_send(3'b110);
      if (delay > 0) begin
         step(delay);
         check({nm, "_no_early_ack"}, port_to_cpu[3], b_tog_seen);
         s_valid = 1'b1;
      end
      wait_ack(100, lat);
      if (exact) check({nm, "_hdr_lat"}, lat, 3);
      else check({nm, "_hdr_ack"}, 32'(lat > 0), 1);
      check({nm, "_s_ready"}, s_ready, 1);
      bd[0] = port_to_cpu[2:0];
      s_valid = 1'b0;
      s_data = 8'($urandom);
      for (int i = 1; i < 4; i++) ack_event({nm, "_rev"}, 3'b000, exact ? 2 : 0, bd[i]);
      check({nm, "_chunk0"}, bd[0], e0);
      check({nm, "_chunk1"}, bd[1], e1);
      check({nm, "_chunk2"}, bd[2], e2);
      check({nm, "_release"}, bd[3], 0);
      check({nm, "_busy_done"}, busy, 0);
      step();
      check({nm, "_s_ready_once"}, sready_cnt - sr0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      int lat;
      int n;
      int e0;
      logic [2:0] bd;
      logic [7:0] d;

      vecs = '{
         '{1'b0, 8'hA7, 3'b101, 3'b001, 3'b011},
         '{1'b1, 8'h5C, 3'b010, 3'b111, 3'b000},
         '{1'b0, 8'h96, 3'b100, 3'b101, 3'b010},
         '{1'b1, 8'hFF, 3'b111, 3'b111, 3'b011},
         '{1'b0, 8'h00, 3'b000, 3'b000, 3'b000},
         '{1'b1, 8'hA7, 3'b101, 3'b001, 3'b011}
      };

      rst_n = 1'b0;
      port_from_cpu = 4'h0;
      s_data = 8'h00;
      s_valid = 1'b0;
      step(3);
      check("rst_port_to_cpu", port_to_cpu, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      step(2);
      check("post_rst_idle", {busy, port_to_cpu}, 0);

      // Directed transfers from the table; downstream always ready.
      man_mready = 1'b1;
      step(2);
      for (int i = 0; i < 6; i++) begin
         if (!vecs[i].dir)
            do_write($sformatf("tbl%0d", i), vecs[i].data, vecs[i].c0, vecs[i].c1, vecs[i].c2,
                     1'(i), 2, 0);
         else
            do_read($sformatf("tbl%0d", i), vecs[i].data, 0, 1'b1, vecs[i].c0, vecs[i].c1,
                    vecs[i].c2);
         step(3);
      end
      check("tbl_no_err", err_cnt, 0);

      // Read with no source data: R_WAIT must neither ack nor time out.
      s_valid = 1'b0;
      s_data = 8'h3A;
      cpu_send(3'b110);
      step(50);
      check("rwait_no_ack", port_to_cpu[3], b_tog_seen);
      check("rwait_no_err", err_cnt, 0);
      check("rwait_busy", busy, 1);
      s_valid = 1'b1;
      wait_ack(2, lat);
      check("rwait_ack_fast", 32'(lat == 1 || lat == 2), 1);
      check("rwait_chunk0", port_to_cpu[2:0], 3'b001);
      s_valid = 1'b0;
      for (int i = 0; i < 3; i++) ack_event("rwait_rev", 3'b000, 2, bd);
      check("rwait_done", busy, 0);
      step(3);

      // Buffer full with no downstream ready: the last chunk waits in W_HOLD.
      man_mready = 1'b0;
      step(2);
      do_write("hold_first", 8'h55, 3'b010, 3'b101, 3'b001, 1'b0, 2, 0);
      m_exp_q.push_back(8'h11);
      ack_event("hold_h", 3'b100, 2, bd);
      ack_event("hold_c0", 3'b000, 2, bd);
      ack_event("hold_c1", 3'b100, 2, bd);
      cpu_send(3'b001);
      wait_ack(10, lat);
      check("hold_no_ack", lat, 32'hFFFF_FFFF);
      check("hold_busy", busy, 1);
      check("hold_old_data", m_data, 8'h55);
      man_mready = 1'b1;
      step();
      man_mready = 1'b0;
      wait_ack(5, lat);
      check("hold_ack", 32'(lat > 0), 1);
      check("hold_m_data", m_data, 8'h11);
      check("hold_m_valid", m_valid, 1);
      check("hold_busy_done", busy, 0);
      man_mready = 1'b1;
      step(3);
      check("hold_drained", m_exp_q.size(), 0);

      // Timeout after a write header.
      e0 = err_cnt;
      ack_event("to_h", 3'b100, 2, bd);
      n = 0;
      do begin
         step();
         n++;
      end while (!err && n < 40);
      check("to_cycles", n, 16);
      check("to_busy", busy, 0);
      check("to_port", port_to_cpu, {b_tog_seen, 3'b000});
      step();
      check("to_err_pulse", err, 0);
      check("to_err_count", err_cnt - e0, 1);
      do_write("to_after", 8'h3C, 3'b001, 3'b111, 3'b000, 1'b1, 2, 0);
      step(3);

      // Non-header event in IDLE: acked, flagged, nothing written.
      e0 = err_cnt;
      cpu_send(3'b000);
      wait_ack(10, lat);
      check("idle_err_lat", lat, 2);
      check("idle_err_flag", err, 1);
      check("idle_err_no_m", m_valid, 0);
      check("idle_err_busy", busy, 0);
      step();
      check("idle_err_count", err_cnt - e0, 1);

      // Event while R_WAIT: abort without an ack.
      e0 = err_cnt;
      s_valid = 1'b0;
      cpu_send(3'b110);
      step(4);
      check("rw_abort_busy_pre", busy, 1);
      cpu_send(3'b000);
      step(2);
      check("rw_abort_err", err, 1);
      check("rw_abort_busy", busy, 0);
      check("rw_abort_port", port_to_cpu, {b_tog_seen, 3'b000});
      step();
      check("rw_abort_count", err_cnt - e0, 1);
      do_read("rw_after", 8'hC3, 0, 1'b1, 3'b110, 3'b000, 3'b011);
      step(2);

      // Random traffic against the byte-level model.
      e0 = err_cnt;
      rand_mready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 0)
            do_write($sformatf("rnd%0d", i), d, d[7:5], d[4:2], {1'b0, d[1:0]},
                     1'($urandom_range(0, 1)), 0, 4);
         else
            do_read($sformatf("rnd%0d", i), d, $urandom_range(0, 4), 1'b0, d[7:5], d[4:2],
                    {1'b0, d[1:0]});
         step($urandom_range(0, 3));
      end
      rand_mready = 1'b0;
      man_mready = 1'b1;
      step(6);
      check("rnd_drained", m_exp_q.size(), 0);
      check("rnd_m_valid_idle", m_valid, 0);
      check("rnd_no_err", err_cnt - e0, 0);

      // Asynchronous reset in the middle of a read (state R2).
      s_data = 8'h96;
      s_valid = 1'b1;
      cpu_send(3'b110);
      wait_ack(10, lat);
      s_valid = 1'b0;
      ack_event("rst_r1", 3'b000, 2, bd);
      check("rst_mid_busy_pre", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_port", port_to_cpu, 0);
      check("rst_async_busy", busy, 0);
      port_from_cpu = 4'h0;
      c_tog = 1'b0;
      b_tog_seen = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(2);
      do_write("rst_after", 8'h6B, 3'b011, 3'b010, 3'b011, 1'b0, 2, 0);
      step(3);
      check("final_drained", m_exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
